// File: rtl/zap_ram_ben_req_ctrl.sv
// Request-side controller for a zap byte-enable pipelined RAM (3-cycle read latency).
// Credit-limited response FIFO guarantees RAM read data is never dropped under back-pressure.

module zap_ram_ben_req_ctrl #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 32,
    parameter int RESP_DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int NB = WIDTH / 8,
    localparam int CW = $clog2(RESP_DEPTH + 1),
    localparam int PW = $clog2(RESP_DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [NB-1:0]    i_req_wen,
    input  logic [AW-1:0]    i_req_addr,
    input  logic [WIDTH-1:0] i_req_wdata,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_rsp_rdata,
    output logic             o_ram_clken,
    output logic [NB-1:0]    o_ram_wr_en,
    output logic [AW-1:0]    o_ram_wr_addr,
    output logic [WIDTH-1:0] o_ram_wr_data,
    output logic [AW-1:0]    o_ram_rd_addr,
    input  logic [WIDTH-1:0] i_ram_rd_data,
    output logic             o_busy
);

    logic             r_v1;
    logic             r_v2;
    logic             r_v3;
    logic [CW-1:0]    r_out;
    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic             r_busy;
    logic [WIDTH-1:0] r_fifo [RESP_DEPTH];

    logic             w_acc;
    logic             w_rd_acc;
    logic             w_wr_acc;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_out_next;
    logic [CW-1:0]    w_cnt_next;

    assign w_acc    = i_req_valid & r_req_ready;
    assign w_rd_acc = w_acc & (i_req_wen == {NB{1'b0}});
    assign w_wr_acc = w_acc & (i_req_wen != {NB{1'b0}});
    assign w_push   = r_v3;
    assign w_pop    = r_rsp_valid & i_rsp_ready;

    // Credit counter next state: reads accepted minus responses consumed.
    always_comb begin
        w_out_next = r_out;
        if (w_rd_acc && !w_pop) begin
            w_out_next = r_out + CW'(1);
        end else if (!w_rd_acc && w_pop) begin
            w_out_next = r_out - CW'(1);
        end else begin
            w_out_next = r_out;
        end
    end

    // FIFO occupancy next state.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_push && !w_pop) begin
            w_cnt_next = r_cnt + CW'(1);
        end else if (!w_push && w_pop) begin
            w_cnt_next = r_cnt - CW'(1);
        end else begin
            w_cnt_next = r_cnt;
        end
    end

    // Read-tracking pipe, pointers, counters and registered status outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_v3        <= 1'b0;
            r_out       <= {CW{1'b0}};
            r_cnt       <= {CW{1'b0}};
            r_wr_ptr    <= {PW{1'b0}};
            r_rd_ptr    <= {PW{1'b0}};
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // Shifting while clken is low is safe: that only happens with v1=v2=0.
            r_v1        <= w_rd_acc;
            r_v2        <= r_v1;
            r_v3        <= r_v2;
            r_out       <= w_out_next;
            r_cnt       <= w_cnt_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_req_ready <= (w_out_next < CW'(RESP_DEPTH));
            r_rsp_valid <= (w_cnt_next != {CW{1'b0}});
            r_busy      <= w_rd_acc | r_v1 | r_v2 | (w_cnt_next != {CW{1'b0}});
        end
    end

    // Response storage; contents need no reset since validity lives in r_cnt.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= i_ram_rd_data;
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = r_fifo[r_rd_ptr];
    assign o_busy        = r_busy;
    assign o_ram_clken   = w_acc | r_v1 | r_v2;
    assign o_ram_wr_en   = w_wr_acc ? i_req_wen : {NB{1'b0}};
    assign o_ram_wr_addr = i_req_addr;
    assign o_ram_rd_addr = i_req_addr;
    assign o_ram_wr_data = i_req_wdata;

    zap_ram_ben_req_ctrl_chk #(
        .CW         (CW),
        .RESP_DEPTH (RESP_DEPTH)
    ) u_chk (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_cnt     (r_cnt),
        .i_out     (r_out)
    );

endmodule

// Protocol checker: the credit scheme must make FIFO overflow unreachable.
module zap_ram_ben_req_ctrl_chk #(
    parameter int CW         = 3,
    parameter int RESP_DEPTH = 4
) (
    input logic          i_clk,
    input logic          i_reset_n,
    input logic          i_push,
    input logic          i_pop,
    input logic [CW-1:0] i_cnt,
    input logic [CW-1:0] i_out
);

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        !(i_push && !i_pop && (i_cnt == CW'(RESP_DEPTH))));

    a_credit_bound: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        (i_out <= CW'(RESP_DEPTH)) && (i_cnt <= i_out));

endmodule
